// File: rtl/ssp_tx_arbiter.sv
// ssp_tx_arbiter: four-way round-robin arbiter that feeds bytes from the
// current packet owner into the SSP Tx FIFO. At most one byte is taken every
// two cycles, which matches the serial byte rate. A stalled owner is released
// after TIMEOUT idle cycles.
//
// Handshake: REQ[i] is the valid flag for byte REQDATA[8i+7:8i]. ACK[i] is
// the ready/consume strobe. The byte moves only in a cycle where both are
// high, and it is written to the FIFO (PWRITE/PWDATA) on the next edge. A
// requester must hold REQ, LAST and the data stable until it sees ACK.
module ssp_tx_arbiter #(
  parameter logic [7:0] TIMEOUT = 8'd255
) (
  input  logic        PCLK,
  input  logic        CLEAR,
  input  logic [3:0]  REQ,
  input  logic [3:0]  LAST,
  input  logic [31:0] REQDATA,
  input  logic        TxFULL,
  output logic [3:0]  GNT,
  output logic [3:0]  ACK,
  output logic        PWRITE,
  output logic [7:0]  PWDATA,
  output logic        BUSY,
  output logic [1:0]  OWNER,
  output logic        ERR
);

  // A timeout of zero would release an owner before it could send anything,
  // so it is treated as one.
  localparam logic [7:0] TIMEOUT_EFF = (TIMEOUT == 8'd0) ? 8'd1 : TIMEOUT;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  gnt_q, gnt_d;
  logic        pwrite_q, pwrite_d;
  logic [7:0]  pwdata_q, pwdata_d;
  logic [1:0]  owner_q, owner_d;
  logic [1:0]  ptr_q, ptr_d;
  logic [7:0]  idle_cnt_q, idle_cnt_d;
  logic        err_q, err_d;

  logic        owner_req;
  logic        owner_last;
  logic [7:0]  owner_byte;
  logic        accept;
  logic        idle_cycle;
  logic        timeout_hit;
  logic        sel_found;
  logic [1:0]  sel_idx;

  // Owner-side view of the request bus, and the accept/idle/timeout events.
  always_comb begin
    owner_req   = REQ[owner_q];
    owner_last  = LAST[owner_q];
    owner_byte  = REQDATA[{owner_q, 3'b000} +: 8];
    accept      = (state_q == OWN) && owner_req && !TxFULL && !pwrite_q;
    idle_cycle  = (state_q == OWN) && !owner_req && !TxFULL && !pwrite_q;
    timeout_hit = (state_q == OWN) && (idle_cnt_q == TIMEOUT_EFF) && !accept;
  end

  // Round-robin search from ptr_q. The loop runs downward so that the
  // smallest offset from the pointer is the one that sticks.
  always_comb begin
    logic [1:0] idx;
    sel_found = 1'b0;
    sel_idx   = ptr_q;
    idx       = ptr_q;
    for (int i = 3; i >= 0; i--) begin
      idx = ptr_q + i[1:0];
      if (REQ[idx]) begin
        sel_found = 1'b1;
        sel_idx   = idx;
      end
    end
  end

  // Next-state and next-output logic for the IDLE/OWN machine.
  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    owner_d    = owner_q;
    ptr_d      = ptr_q;
    idle_cnt_d = idle_cnt_q;
    err_d      = 1'b0;
    pwrite_d   = accept;
    pwdata_d   = accept ? owner_byte : pwdata_q;

    case (state_q)
      IDLE: begin
        if (sel_found) begin
          state_d    = OWN;
          owner_d    = sel_idx;
          gnt_d      = 4'b0001 << sel_idx;
          idle_cnt_d = 8'd0;
        end
      end
      OWN: begin
        if (accept) begin
          idle_cnt_d = 8'd0;
          if (owner_last) begin
            state_d = IDLE;
            gnt_d   = 4'b0000;
            ptr_d   = owner_q + 2'd1;
          end
        end else if (timeout_hit) begin
          state_d = IDLE;
          gnt_d   = 4'b0000;
          ptr_d   = owner_q + 2'd1;
          err_d   = 1'b1;
        end else if (idle_cycle) begin
          idle_cnt_d = idle_cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 4'b0000;
      end
    endcase
  end

  // State register. CLEAR overrides every other event.
  always_ff @(posedge PCLK) begin
    if (CLEAR) begin
      state_q    <= IDLE;
      gnt_q      <= 4'b0000;
      pwrite_q   <= 1'b0;
      pwdata_q   <= 8'h00;
      owner_q    <= 2'd0;
      ptr_q      <= 2'd0;
      idle_cnt_q <= 8'd0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      pwrite_q   <= pwrite_d;
      pwdata_q   <= pwdata_d;
      owner_q    <= owner_d;
      ptr_q      <= ptr_d;
      idle_cnt_q <= idle_cnt_d;
      err_q      <= err_d;
    end
  end

  // Output mapping. BUSY doubles as the visible FSM state.
  always_comb begin
    ACK    = accept ? (4'b0001 << owner_q) : 4'b0000;
    GNT    = gnt_q;
    PWRITE = pwrite_q;
    PWDATA = pwdata_q;
    BUSY   = (state_q == OWN);
    OWNER  = owner_q;
    ERR    = err_q;
  end

endmodule
